// File: rtl/mem_line_responder.sv
// Line-granular main-memory responder below the L2 cache.
// Accepts one read-line or write-line request at a time. Read data comes back
// as a single-cycle pulse after READ_LAT cycles. Writes land at the accept
// edge and hold ready low for WRITE_LAT cycles.
module mem_line_responder #(
    parameter int ADDR_W      = 32,
    parameter int LINE_BYTES  = 32,
    parameter int LINE_W      = LINE_BYTES * 8,
    parameter int DEPTH_LINES = 256,
    parameter int READ_LAT    = 4,
    parameter int WRITE_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic              mem_req_rw,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_wline,
    output logic              mem_resp_valid,
    output logic [LINE_W-1:0] mem_resp_rline,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              oob_err
);

    localparam int OFF     = $clog2(LINE_BYTES);
    localparam int IDX     = $clog2(DEPTH_LINES);
    localparam int WORDS   = LINE_BYTES / 4;
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2,
        WR_WAIT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LINE_W-1:0] mem [DEPTH_LINES];
    logic [IDX-1:0]    req_idx;
    logic [IDX-1:0]    rd_idx;
    logic [IDX-1:0]    resp_idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic              accept;
    logic              req_oob;
    logic              unused_offset_bits;

    // The offset bits only select a byte inside the line. A line-granular
    // memory has no use for them.
    assign unused_offset_bits = ^mem_req_addr[OFF-1:0];

    assign req_idx       = mem_req_addr[OFF+IDX-1:OFF];
    assign req_oob       = (mem_req_addr >> (OFF + IDX)) != '0;
    assign mem_req_ready = (state == IDLE);
    assign accept        = mem_req_valid && mem_req_ready;
    // A latency-1 read goes to RESP from IDLE, so it indexes with the live request.
    assign resp_idx      = (state == IDLE) ? req_idx : rd_idx;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before the edge regardless of block order.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic. A read response is registered on the edge where the
    // down-counter finishes, which puts the pulse READ_LAT cycles after accept.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next
        // unassigned and infers a latch.
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mem_req_rw)         state_next = WR_WAIT;
                    else if (READ_LAT == 1) state_next = RESP;
                    else                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: if (lat_cnt == LAT_W'(1)) state_next = RESP;
            RESP:    state_next = IDLE;
            WR_WAIT: if (lat_cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Line storage. Writes land at the accept edge. Reset restores the
    // address-pattern preload.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this array is reset on purpose. Each word comes back as its own
        // byte address after reset, which costs flops instead of a RAM macro.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_LINES; i++) begin
                for (int w = 0; w < WORDS; w++) begin
                    mem[i][32*w +: 32] <= 32'(i * LINE_BYTES + 4 * w);
                end
            end
        end else if (accept && mem_req_rw) begin
            mem[req_idx] <= mem_req_wline;
        end
    end

    // Latency counter, latched read index, response register, counters, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt        <= '0;
            rd_idx         <= '0;
            mem_resp_valid <= 1'b0;
            mem_resp_rline <= '0;
            rd_count       <= '0;
            wr_count       <= '0;
            oob_err        <= 1'b0;
        end else begin
            mem_resp_valid <= (state_next == RESP);
            if (state != RESP && state_next == RESP) begin
                mem_resp_rline <= mem[resp_idx];
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_oob) oob_err <= 1'b1;
                        if (mem_req_rw) begin
                            lat_cnt <= LAT_W'(WRITE_LAT - 1);
                            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                        end else begin
                            lat_cnt <= LAT_W'(READ_LAT - 1);
                            rd_idx  <= req_idx;
                            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder.
// A directed vector table and a few hand-written sequences are followed by
// randomized traffic. All of it is checked against a line-array reference
// model that is kept in the bench.
module tb_mem_line_responder;

    localparam int READ_LAT  = 4;
    localparam int WRITE_LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [255:0] mem_req_wline;
    logic         mem_resp_valid;
    logic [255:0] mem_resp_rline;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;
    logic         oob_err;

    int checks = 0;
    int errors = 0;

    // Reference model: the line array plus the expected counters and error flag.
    logic [255:0] model_mem [256];
    int           rd_m;
    int           wr_m;
    bit           oob_m;

    typedef struct {
        bit           rw;
        logic [31:0]  addr;
        logic [255:0] wline;
        bit           hold;
        bit           chk_words;
        logic [31:0]  exp_w0;
        logic [31:0]  exp_w7;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    mem_line_responder #(
        .READ_LAT  (READ_LAT),
        .WRITE_LAT (WRITE_LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wline  (mem_req_wline),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rline (mem_resp_rline),
        .rd_count       (rd_count),
        .wr_count       (wr_count),
        .oob_err        (oob_err)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Preload rule: each 32-bit word holds its own byte address.
    function automatic logic [255:0] pattern(input int line);
        logic [255:0] p;
        for (int w = 0; w < 8; w++) p[32*w +: 32] = 32'(line * 32 + 4 * w);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = pattern(i);
        rd_m  = 0;
        wr_m  = 0;
        oob_m = 0;
    endtask

    task automatic check_status();
        check("rd_count", rd_count, rd_m);
        check("wr_count", wr_count, wr_m);
        check("oob_err", oob_err, oob_m);
    endtask

    // Present one request at a negedge and monitor it until ready returns.
    // With hold set, valid stays high while the responder is busy, and rw and
    // addr are scrambled so that a second accept or a late sample would show.
    task automatic issue(input bit t_rw, input logic [31:0] t_addr, input logic [255:0] t_wline,
                         input bit hold, output logic [255:0] got);
        int           waits;
        int           busy;
        int           resp_at;
        int           resp_cnt;
        int           idx;
        bit           done;
        logic [255:0] exp;
        logic [255:0] cap;
        mem_req_valid = 1'b1;
        mem_req_rw    = t_rw;
        mem_req_addr  = t_addr;
        mem_req_wline = t_wline;
        waits = 0;
        while (!mem_req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check("accept_wait", waits, 0);

        idx = int'(t_addr[12:5]);
        if ((t_addr >> 13) != 0) oob_m = 1;
        exp = model_mem[idx];
        if (t_rw) begin
            model_mem[idx] = t_wline;
            if (wr_m < 65535) wr_m++;
        end else begin
            if (rd_m < 65535) rd_m++;
        end

        busy = 0; resp_at = 0; resp_cnt = 0; done = 0; cap = '0;
        for (int n = 1; n <= 50 && !done; n++) begin
            @(negedge clk);
            if (mem_resp_valid) begin
                resp_cnt++;
                if (resp_at == 0) begin
                    resp_at = n;
                    cap     = mem_resp_rline;
                end
            end
            if (mem_req_ready) begin
                done          = 1;
                mem_req_valid = 1'b0;
            end else begin
                busy++;
                if (hold) begin
                    mem_req_rw   = ~mem_req_rw;
                    mem_req_addr = mem_req_addr ^ 32'h0000_0020;
                end else begin
                    mem_req_valid = 1'b0;
                end
            end
        end
        check("ready_returned", done, 1);
        if (!t_rw) begin
            check("resp_latency", resp_at, READ_LAT);
            check("resp_pulses", resp_cnt, 1);
            check("rd_busy", busy, READ_LAT);
            check("rline", cap, exp);
            check("rline_hold", mem_resp_rline, exp);
        end else begin
            check("wr_no_resp", resp_cnt, 0);
            check("wr_busy", busy, WRITE_LAT);
        end
        check_status();
        got = cap;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] got;
        logic [255:0] rl;
        logic [31:0]  ra;
        int           pulses;

        vecs[0] = '{rw: 1'b0, addr: 32'h40,   wline: '0,                hold: 1'b0, chk_words: 1'b1, exp_w0: 32'h40,       exp_w7: 32'h5C};
        vecs[1] = '{rw: 1'b1, addr: 32'h1FE0, wline: {32{8'hA5}},       hold: 1'b0, chk_words: 1'b0, exp_w0: 32'h0,        exp_w7: 32'h0};
        vecs[2] = '{rw: 1'b0, addr: 32'h1FE0, wline: '0,                hold: 1'b0, chk_words: 1'b1, exp_w0: 32'hA5A5A5A5, exp_w7: 32'hA5A5A5A5};
        vecs[3] = '{rw: 1'b0, addr: 32'h80,   wline: '0,                hold: 1'b1, chk_words: 1'b1, exp_w0: 32'h80,       exp_w7: 32'h9C};
        vecs[4] = '{rw: 1'b1, addr: 32'h0,    wline: {8{32'hCAFEF00D}}, hold: 1'b0, chk_words: 1'b0, exp_w0: 32'h0,        exp_w7: 32'h0};
        vecs[5] = '{rw: 1'b0, addr: 32'h20,   wline: '0,                hold: 1'b0, chk_words: 1'b1, exp_w0: 32'h20,       exp_w7: 32'h3C};
        vecs[6] = '{rw: 1'b0, addr: 32'h0,    wline: '0,                hold: 1'b0, chk_words: 1'b1, exp_w0: 32'hCAFEF00D, exp_w7: 32'hCAFEF00D};
        vecs[7] = '{rw: 1'b0, addr: 32'h2040, wline: '0,                hold: 1'b0, chk_words: 1'b1, exp_w0: 32'h40,       exp_w7: 32'h5C};
        vecs[8] = '{rw: 1'b0, addr: 32'h60,   wline: '0,                hold: 1'b0, chk_words: 1'b1, exp_w0: 32'h60,       exp_w7: 32'h7C};

        rst_n         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wline = '0;
        model_reset();

        // Reset state, checked while reset is held and again after release.
        @(negedge clk);
        check("rst_ready", mem_req_ready, 1);
        check("rst_resp_valid", mem_resp_valid, 0);
        check("rst_rline", mem_resp_rline, '0);
        check_status();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", mem_req_ready, 1);

        // Directed table, back to back.
        foreach (vecs[i]) begin
            issue(vecs[i].rw, vecs[i].addr, vecs[i].wline, vecs[i].hold, got);
            if (vecs[i].chk_words) begin
                check($sformatf("vec%0d_w0", i), got[31:0], vecs[i].exp_w0);
                check($sformatf("vec%0d_w7", i), got[255:224], vecs[i].exp_w7);
            end
        end

        // Reset two cycles into a read: the response is dropped and the preload returns.
        issue(1'b1, 32'h40, {32{8'h11}}, 1'b0, got);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 32'h40;
        @(negedge clk);
        mem_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_ready", mem_req_ready, 1);
        check("midrst_resp_valid", mem_resp_valid, 0);
        check_status();
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mem_resp_valid) pulses++;
        end
        check("midrst_no_resp", pulses, 0);
        issue(1'b0, 32'h40, '0, 1'b0, got);
        check("midrst_restored_w0", got[31:0], 32'h40);

        // Randomized traffic over a small index range, so that reads often hit written lines.
        for (int t = 0; t < 150; t++) begin
            ra = (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) ra = ra | (32'($urandom_range(1, 255)) << 13);
            for (int w = 0; w < 8; w++) rl[32*w +: 32] = $urandom;
            issue(1'($urandom_range(0, 1)), ra, rl, 1'($urandom_range(0, 3) == 0), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
